// File: rtl/if_id_buf_pkg.sv
// Shared widths, stall encoding and entry type for the IF/ID decoupling buffer.
// Also carries the default buffer depth used by the pipeline.
package if_id_buf_pkg;

  localparam int unsigned InstBus     = 32;
  localparam int unsigned InstAddrBus = 32;
  localparam int unsigned IfIdDepth   = 2;

  localparam logic        Stop     = 1'b1;
  localparam logic        NoStop   = 1'b0;
  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  // Bit positions inside the control-unit stall vector.
  localparam int unsigned StallIfId = 1;
  localparam int unsigned StallId   = 2;

  typedef struct packed {
    logic [InstAddrBus-1:0] pc;
    logic [InstBus-1:0]     inst;
  } if_id_entry_t;

  localparam if_id_entry_t Bubble = '{pc: ZeroWord, inst: ZeroWord};

endpackage

// File: rtl/sync_fifo_ptr.sv
// Read/write pointer and occupancy manager for a small power-of-two FIFO.
// Full and empty come from the count alone; flush zeroes everything.
module sync_fifo_ptr #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned PTR_W = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [PTR_W-1:0] wr_ptr_o,
  output logic [PTR_W-1:0] rd_ptr_o,
  output logic [PTR_W:0]   count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam logic [PTR_W:0] FullCount = (PTR_W + 1)'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + (PTR_W + 1)'(1);
        2'b01:   count_d = count_q - (PTR_W + 1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign wr_ptr_o = wr_ptr_q;
  assign rd_ptr_o = rd_ptr_q;
  assign count_o  = count_q;
  assign full_o   = (count_q == FullCount);
  assign empty_o  = (count_q == '0);

endmodule

// File: rtl/if_id_buf.sv
// IF/ID decoupling buffer: in-order FIFO of {pc, inst} pairs feeding decode.
// Presents a zero bubble when empty and requests a stall when full.
module if_id_buf
  import if_id_buf_pkg::*;
#(
  parameter int unsigned DEPTH = IfIdDepth,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       stall,
  input  logic             flush,
  input  logic             if_valid_i,
  input  logic [31:0]      if_pc_i,
  input  logic [31:0]      if_inst_i,
  output logic             id_valid_o,
  output logic [31:0]      id_pc_o,
  output logic [31:0]      id_inst_o,
  output logic [PTR_W:0]   count_o,
  output logic             stallreq_o
);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  if_id_entry_t     head;
  if_id_entry_t     mem_q [DEPTH];

  // Only the IF/ID freeze and decode-stop bits matter to this stage.
  logic unused_stall;
  assign unused_stall = ^{stall[5:3], stall[0]};

  assign push = if_valid_i & (stall[StallIfId] == NoStop) & ~flush & ~full;
  assign pop  = ~empty & (stall[StallId] != Stop) & ~flush;

  sync_fifo_ptr #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_ptr (
    .clk_i    (clk),
    .rst_ni   (rst),
    .push_i   (push),
    .pop_i    (pop),
    .flush_i  (flush),
    .wr_ptr_o (wr_ptr),
    .rd_ptr_o (rd_ptr),
    .count_o  (count_o),
    .full_o   (full),
    .empty_o  (empty)
  );

  // Storage is never reset; validity is carried entirely by the count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr] <= '{pc: if_pc_i, inst: if_inst_i};
    end
  end

  always_comb begin
    head = Bubble;
    if (!empty) head = mem_q[rd_ptr];
  end

  assign id_valid_o = ~empty;
  assign id_pc_o    = head.pc;
  assign id_inst_o  = head.inst;
  assign stallreq_o = full;

endmodule

// File: doc/if_id_buf.md
Name: if_id_buf

Overview:
- Decoupling buffer between the fetch stage (PC register plus instruction ROM) and the decode stage.
- Captures each fetched {pc, inst} pair in a small in-order FIFO and presents the oldest entry to decode.
- Lets fetch run ahead while decode is stalled, and raises a stall request to the control unit when the FIFO is full.
- Empties on a pipeline flush. While empty, emits a NOP bubble (all zeros).

Parameters:
- DEPTH, 2, number of FIFO entries; must be a power of two, legal range 2..8.
- PTR_W, 1, pointer width; equals log2(DEPTH).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset; asserted when 0.
- stall  in  6  control-unit stall vector; bit 1 = freeze IF/ID write, bit 2 = decode stalled (1 = Stop).
- flush  in  1  pipeline flush from the control unit; kills all buffered entries.
- if_valid_i  in  1  fetch produced a valid instruction this cycle (fetch chip-enable active).
- if_pc_i  in  32  PC of the fetched instruction.
- if_inst_i  in  32  fetched instruction word.
- id_valid_o  out  1  head entry valid.
- id_pc_o  out  32  PC of head entry; 0 when empty.
- id_inst_o  out  32  instruction of head entry; 0 (NOP) when empty.
- count_o  out  PTR_W+1  number of occupied entries, 0..DEPTH.
- stallreq_o  out  1  FIFO full; the control unit must assert stall[0] and stall[1] in the same cycle.

Behaviour:
- Reset (rst=0, asynchronous):
  - read and write pointers = 0, count = 0;
  - all valid bits = 0;
  - outputs: id_valid_o=0, id_pc_o=0, id_inst_o=0, count_o=0, stallreq_o=0.
  - Storage data need not be cleared.
- push = if_valid_i & ~stall[1] & ~flush & ~full.
- pop = id_valid_o & ~stall[2] & ~flush.
- Full/empty are derived from count only (count==DEPTH / count==0). Pointers wrap modulo DEPTH.
- On push: write {if_pc_i, if_inst_i} at the write pointer, then advance the write pointer.
- On pop: advance the read pointer.
- Count update: push&~pop gives +1; pop&~push gives -1; push&pop leaves count unchanged.
- Simultaneous push and pop:
  - when 0 < count < DEPTH, both take effect in the same cycle;
  - when count==0, pop is impossible (id_valid_o=0), so push only;
  - when full, push is blocked, so pop only; the freed slot is usable next cycle.
- Output timing:
  - id_* are driven from the storage entry at the read pointer, gated by empty. They are register outputs with no combinational path from if_*_i.
  - Latency from push to visibility at decode is 1 cycle: pushed at edge N, visible after edge N.
- Empty: id_valid_o=0, id_pc_o=0, id_inst_o=0 regardless of storage contents.
- Flush (flush=1 at an edge):
  - pointers and count go to 0;
  - any simultaneous push or pop is discarded;
  - outputs show the bubble from the next cycle.
  - flush has priority over stall and push.
- stallreq_o = (count==DEPTH). It is derived from registered state only, so it introduces no loop through the control unit.
- stall[1]=1 with if_valid_i=1: the instruction is not captured. Upstream holds its PC because the control unit also stalls the PC register.
- if_valid_i=1 while full is an upstream protocol violation. The instruction is dropped and state is unchanged; the bench flags it with an assertion.
- Reset asserted mid-operation: all contents are lost immediately and outputs go to reset values asynchronously. Deassertion is synchronised externally.

Decomposition:
- Shared defines (existing global defines file):
  - `RegBus, `InstBus, `InstAddrBus widths;
  - `Stop / `NoStop;
  - `ZeroWord used as the bubble value.
- New constant: `IfIdDepth default 2.
- One natural sub-module, sync_fifo_ptr: pointer/count manager (wrap, full, empty). The data array and output gating stay in if_id_buf.

Test Plan:
- Reset: hold rst=0 for 3 cycles with if_valid_i=1 -> id_valid_o=0, id_inst_o=0, count_o=0, stallreq_o=0. Release; push pc=0x0, inst=0x34011100 -> next cycle id_valid_o=1, id_pc_o=0x0, id_inst_o=0x34011100.
- Streaming: push pc 0x0, 0x4, 0x8, 0xC on consecutive cycles with stall=0 -> decode sees them in order, one per cycle, 1-cycle latency; count_o stays 1.
- Decode stall: stall[2]=1 for 4 cycles while fetch pushes 0x10, 0x14 (DEPTH=2) -> count_o=2, stallreq_o=1. A third if_valid_i is blocked (test drives stall[1]=1). Release -> 0x10 then 0x14 pop in order, stallreq_o drops after the first pop.
- Full with concurrent pop: count=2, stall[2]=0, if_valid_i=1 -> head pops, push blocked, count_o=1. Next cycle push accepted, count_o=2.
- Flush: count=2 with entries 0x20 and 0x24, assert flush together with if_valid_i=1 (pc 0x28) -> next cycle count_o=0, id_valid_o=0, id_inst_o=0; 0x28 is never delivered.
- Async reset mid-stream: drop rst between edges while count=1 -> outputs zero immediately, before the next edge. After release, the first push behaves as in the reset scenario; also run with DEPTH=4 to check pointer wrap over 10 entries.
